multi_ce_generator: RTL
=======================

# multi_ce_generator

Multi-channel, drift-free sample clock-enable generator. It drives up to NUM_CH independent single-cycle `ce` strobes from one system clock, each at a software-programmed period in nanoseconds. Each channel uses a remainder-keeping phase accumulator, so no divider is needed and non-integer period/clock ratios average exactly. Each channel also has a programmable start phase and a continuous or one-shot mode. It sits between the register file and the sample-pipeline stages (ADC capture, filters, DAC output) that each need their own enable.

## Interface
- `NUM_CH`, 4: number of independent channels (1..16).
- `CNT_W`, 32: width of period/phase/accumulator values, in ns.
- `CLK_PERIOD_NS`, 10: `clk` period in ns; constant added to every accumulator each cycle; must be ≥1.
- `clk`  in  1  system clock; every flop is on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high; clears all state and outputs immediately.
- `en`  in  NUM_CH  per-channel enable; level-sensitive.
- `mode`  in  NUM_CH  0 = continuous, 1 = one-shot (single `ce` per load).
- `load`  in  NUM_CH  per-channel single-cycle strobe; samples period/phase and (re)starts the channel.
- `period_ns`  in  NUM_CH*CNT_W  channel i occupies bits [i*CNT_W +: CNT_W].
- `phase_ns`  in  NUM_CH*CNT_W  initial accumulator value per channel, same packing.
- `ce`  out  NUM_CH  registered single-cycle enable strobes.
- `busy`  out  NUM_CH  channel in RUN state.
- `err`  out  NUM_CH  sticky per-channel: last load rejected; cleared by the next valid load or `rst`.

## Operation
- Per-channel state: IDLE, RUN, DONE. Also latched `per` (CNT_W), `acc` (CNT_W), `err`.
- `load` with `en`=1:
  - If `period_ns` < CLK_PERIOD_NS or `phase_ns` ≥ `period_ns`: set err=1, go to IDLE.
  - Otherwise: per<=period_ns, acc<=phase_ns, err<=0, go to RUN.
- `load` with `en`=0 is ignored. Period/phase inputs are sampled only on `load`, so later input changes have no effect.
- RUN, every cycle: sum = acc + CLK_PERIOD_NS, computed CNT_W+1 bits wide (never overflows).
  - If sum ≥ per: ce<=1 and acc<=sum−per.
  - Else: ce<=0 and acc<=sum.
- One-shot mode: the cycle that sets ce also moves the channel to DONE. DONE holds ce=0 until the next `load`.
- `en` falling in any state: go to IDLE, acc<=0, ce<=0 on that edge. `en` rising does not restart the channel; a `load` is required.
- `load` in RUN on a crossing cycle: load wins. No ce is issued and the accumulator restarts from the new phase.
- Rate guarantee: over N pulses, the elapsed cycle count is within ±1 of N*per/CLK_PERIOD_NS. There is no cumulative drift.
- Channels are fully independent. Simultaneous loads and crossings on different channels do not interact.

## Timing
- Reset values: ce=0, busy=0, err=0, state IDLE, acc=0, per=0.
- Load latency: the load sampled at edge E0 gives busy=1 after E0. Accumulation starts at E1.
- First pulse, phase p: ce rises at edge Ek, where k is the smallest k with p + k*CLK_PERIOD_NS ≥ per. Pulse width is exactly one cycle.
- Minimum legal period (per = CLK_PERIOD_NS): ce is high every cycle from E1.
- `err` is visible the cycle after the rejecting load.
- `rst` asserted mid-operation: outputs drop asynchronously, without waiting for a clock edge. After release, all channels stay IDLE until loaded.

## Structure
- Shared package `ce_gen_pkg` holds:
  - the state encoding (IDLE=0, RUN=1, DONE=2, 2 bits);
  - the mode constants MODE_CONT/MODE_ONESHOT;
  - a function that extracts channel i's CNT_W slice from a packed bus.
- Sub-module `ce_channel` holds one channel's state machine and accumulator, with parameters CNT_W and CLK_PERIOD_NS. The top level is a generate loop of NUM_CH instances plus bus slicing only.

## Test plan
- Integer ratio: CLK=10, ch0 period 30, phase 0, continuous, load at E0 -> ce at E3, E6, E9…; busy=1 throughout.
- Fractional ratio: period 25, phase 0 -> ce at E3, E5, E8, E10. Over 1000 pulses the elapsed count is exactly 2500 cycles.
- Phase and one-shot: period 100, phase 70, mode=1 -> single ce at E3, then DONE with busy=0 and no further ce. A reload at E20 gives the next ce at E23.
- Error handling: period 5 (< CLK), or phase 40 with period 30 -> err=1, busy=0, no ce. A subsequent valid load clears err.
- Control and independence: load collides with a crossing edge -> no ce, restart from the new phase. `en` dropped mid-run -> ce stops on the next edge. Four channels with periods 10/20/30/40 loaded together -> each meets its own pattern.
- Reset: `rst` asserted between edges while ce=1 -> ce, busy and err go 0 without a clock edge. After release, no ce until a new load.

Source files
------------

// File: rtl/ce_gen_pkg.sv
// Shared types and helpers for the multi-channel clock-enable generator.
package ce_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ch_state_e;

    localparam logic MODE_CONT    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    // Upper bounds for the slice helper: 16 channels of at most 64 bits each.
    localparam int SLICE_MAX_W = 64;
    localparam int BUS_MAX_W   = 16 * SLICE_MAX_W;

    function automatic logic [SLICE_MAX_W-1:0] ch_slice(
        input logic [BUS_MAX_W-1:0] bus,
        input int unsigned          idx,
        input int unsigned          w
    );
        logic [BUS_MAX_W-1:0]   shifted;
        logic [SLICE_MAX_W-1:0] mask;
        shifted = bus >> (idx * w);
        mask    = {SLICE_MAX_W{1'b1}} >> (SLICE_MAX_W - w);
        return shifted[SLICE_MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/ce_channel.sv
// One clock-enable channel: remainder-keeping phase accumulator with
// continuous / one-shot modes and load validation.
module ce_channel
    import ce_gen_pkg::*;
#(
    parameter int CNT_W         = 32,
    parameter int CLK_PERIOD_NS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [CNT_W-1:0] period_ns,
    input  logic [CNT_W-1:0] phase_ns,
    output logic             ce,
    output logic             busy,
    output logic             err
);

    localparam logic [CNT_W-1:0] CLK_STEP = CNT_W'(CLK_PERIOD_NS);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic             mode_q, mode_d;
    logic             err_q, err_d;
    logic             ce_q, ce_d;

    logic [CNT_W:0]   sum;
    logic             crossing;
    logic             load_ok;

    // One extra bit keeps acc + step from wrapping before the compare.
    assign sum      = {1'b0, acc_q} + {1'b0, CLK_STEP};
    assign crossing = sum >= {1'b0, per_q};
    assign load_ok  = (period_ns >= CLK_STEP) && (phase_ns < period_ns);

    // NOTE: every next-state variable gets its hold value first, so no path
    // through the branches below can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        per_d   = per_q;
        acc_d   = acc_q;
        mode_d  = mode_q;
        err_d   = err_q;
        ce_d    = 1'b0;

        if (!en) begin
            state_d = ST_IDLE;
            acc_d   = '0;
        end else if (load) begin
            if (load_ok) begin
                per_d   = period_ns;
                acc_d   = phase_ns;
                mode_d  = mode;
                err_d   = 1'b0;
                state_d = ST_RUN;
            end else begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end
        end else if (state_q == ST_RUN) begin
            if (crossing) begin
                ce_d  = 1'b1;
                acc_d = CNT_W'(sum - {1'b0, per_q});
                if (mode_q == MODE_ONESHOT) begin
                    state_d = ST_DONE;
                end
            end else begin
                acc_d = sum[CNT_W-1:0];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            per_q   <= '0;
            acc_q   <= '0;
            mode_q  <= MODE_CONT;
            err_q   <= 1'b0;
            ce_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            acc_q   <= acc_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            ce_q    <= ce_d;
        end
    end

    assign ce   = ce_q;
    assign busy = (state_q == ST_RUN);
    assign err  = err_q;

endmodule

// File: rtl/multi_ce_generator.sv
// Multi-channel drift-free sample clock-enable generator: one ce_channel
// per channel, with period/phase buses sliced per channel.
module multi_ce_generator
    import ce_gen_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int CNT_W         = 32,
    parameter int CLK_PERIOD_NS = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       mode,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*CNT_W-1:0] period_ns,
    input  logic [NUM_CH*CNT_W-1:0] phase_ns,
    output logic [NUM_CH-1:0]       ce,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       err
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] ch_period;
        logic [CNT_W-1:0] ch_phase;

        assign ch_period = CNT_W'(ch_slice(BUS_MAX_W'(period_ns), i, CNT_W));
        assign ch_phase  = CNT_W'(ch_slice(BUS_MAX_W'(phase_ns), i, CNT_W));

        ce_channel #(
            .CNT_W        (CNT_W),
            .CLK_PERIOD_NS(CLK_PERIOD_NS)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en[i]),
            .mode     (mode[i]),
            .load     (load[i]),
            .period_ns(ch_period),
            .phase_ns (ch_phase),
            .ce       (ce[i]),
            .busy     (busy[i]),
            .err      (err[i])
        );
    end

endmodule
